// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI slave: FSM state encoding,
//            status word bit positions, CPU write field offsets and a
//            status word packing helper.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame state: IDLE while chip select is high, SHIFT during a frame
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    // Status word bit positions (read data)
    localparam int STAT_RX_DATA_LSB = 0;
    localparam int STAT_RX_FULL     = 8;
    localparam int STAT_TX_FULL     = 9;
    localparam int STAT_RX_OVERRUN  = 10;
    localparam int STAT_TX_UNDERRUN = 11;

    // Write field offsets (write data)
    localparam int FLD_TX_DATA_LSB  = 0;
    localparam int FLD_CLR_RX_OVR   = 8;
    localparam int FLD_CLR_TX_UND   = 9;
    localparam int FLD_IRQ_EN_LSB   = 16;

    // Byte lanes
    localparam int LANE_TX_DATA     = 0;
    localparam int LANE_CLEAR       = 1;
    localparam int LANE_IRQ_EN      = 2;

    // Byte shifted out when the CPU has not supplied one
    localparam logic [7:0] IDLE_FILL = 8'hFF;

    // Build the CPU-visible status word
    function automatic logic [31:0] pack_status(
        input logic       tx_underrun,
        input logic       rx_overrun,
        input logic       tx_full,
        input logic       rx_full,
        input logic [7:0] rx_data
    );
        logic [31:0] w;
        w = 32'd0;
        w[STAT_RX_DATA_LSB +: 8] = rx_data;
        w[STAT_RX_FULL]          = rx_full;
        w[STAT_TX_FULL]          = tx_full;
        w[STAT_RX_OVERRUN]       = rx_overrun;
        w[STAT_TX_UNDERRUN]      = tx_underrun;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync
// Purpose  : Multi-stage flip-flop synchronizer with a configurable reset
//            value, used to bring the asynchronous SPI pins into clk.
//            STAGES must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw pin through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : SPI mode-0 slave, MSB first, 8-bit frames, with a simple CPU
//            request/ready register interface. All logic runs on clk; the
//            SPI pins are synchronized and their edges detected from the
//            last two synchronized samples.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [3:0]  lane,
    input  logic        wr,
    input  logic        valid,
    output logic        ready,
    output logic        irq,
    input  logic        cs_n,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);

    // ------------------------------------------------------------------
    // Pin synchronization and edge detection
    // ------------------------------------------------------------------
    logic sck_s, cs_s, mosi_s;
    logic sck_prev, cs_prev;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk (clk), .rst (rst), .d (sck),  .q (sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk (clk), .rst (rst), .d (cs_n), .q (cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
        .clk (clk), .rst (rst), .d (mosi), .q (mosi_s)
    );

    // Hold the previous synchronized sample of sck and cs_n
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise;
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    spi_state_t  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shifter;
    logic [6:0]  rx_shift;
    logic        reload_pending;

    logic [7:0]  tx_data;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_full;
    logic        rx_overrun;
    logic        tx_underrun;
    logic [1:0]  irq_en;

    // Frame events; chip-select release takes priority over sck edges
    logic in_frame, load_evt, reload_evt, byte_evt, tx_take;
    logic [7:0] tx_next;

    assign in_frame   = (state == ST_SHIFT) & ~cs_rise;
    assign load_evt   = (state == ST_IDLE) & cs_fall;
    assign reload_evt = in_frame & sck_fall & reload_pending;
    assign byte_evt   = in_frame & sck_rise & (bit_cnt == 3'd7);
    assign tx_take    = load_evt | reload_evt;
    // The byte taken uses the pre-write tx state, so a same-cycle CPU
    // write lands after the reload
    assign tx_next    = tx_full ? tx_data : IDLE_FILL;

    // ------------------------------------------------------------------
    // CPU request decode
    // ------------------------------------------------------------------
    logic accept, wr_acc, rd_acc;
    assign accept = valid & ~ready;
    assign wr_acc = accept & wr;
    assign rd_acc = accept & ~wr;

    // ------------------------------------------------------------------
    // Frame FSM: shifter, bit counter and registered miso/miso_oe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bit_cnt        <= 3'd0;
            shifter        <= IDLE_FILL;
            rx_shift       <= 7'd0;
            reload_pending <= 1'b0;
            miso           <= 1'b1;
            miso_oe        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    miso    <= 1'b1;
                    miso_oe <= 1'b0;
                    if (cs_fall) begin
                        state          <= ST_SHIFT;
                        bit_cnt        <= 3'd0;
                        shifter        <= tx_next;
                        reload_pending <= 1'b0;
                        miso           <= tx_next[7];
                        miso_oe        <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Partial byte is simply dropped
                        state          <= ST_IDLE;
                        bit_cnt        <= 3'd0;
                        reload_pending <= 1'b0;
                        shifter        <= IDLE_FILL;
                        miso           <= 1'b1;
                        miso_oe        <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[5:0], mosi_s};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            reload_pending <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (reload_pending) begin
                            shifter        <= tx_next;
                            miso           <= tx_next[7];
                            reload_pending <= 1'b0;
                        end else begin
                            shifter <= {shifter[6:0], 1'b1};
                            miso    <= shifter[6];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CPU registers, flags and the request/ready handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data     <= 8'd0;
            tx_full     <= 1'b0;
            rx_data     <= 8'd0;
            rx_full     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            irq_en      <= 2'b00;
            ready       <= 1'b0;
            dout        <= 32'd0;
        end else begin
            ready <= accept;

            // Read samples the flags as they stood before this cycle
            if (rd_acc) begin
                dout <= pack_status(tx_underrun, rx_overrun, tx_full,
                                    rx_full, rx_data);
            end

            if (byte_evt) begin
                rx_data <= {rx_shift, mosi_s};
            end

            // A completing byte wins over a read-clear
            if (byte_evt) begin
                rx_full <= 1'b1;
            end else if (rd_acc) begin
                rx_full <= 1'b0;
            end

            // Setting events win over software clears so none is lost
            if (byte_evt && rx_full) begin
                rx_overrun <= 1'b1;
            end else if (wr_acc && lane[LANE_CLEAR] && din[FLD_CLR_RX_OVR]) begin
                rx_overrun <= 1'b0;
            end

            if (tx_take && !tx_full) begin
                tx_underrun <= 1'b1;
            end else if (wr_acc && lane[LANE_CLEAR] && din[FLD_CLR_TX_UND]) begin
                tx_underrun <= 1'b0;
            end

            // A CPU write of tx_data wins over the consuming reload
            if (wr_acc && lane[LANE_TX_DATA]) begin
                tx_data <= din[FLD_TX_DATA_LSB +: 8];
                tx_full <= 1'b1;
            end else if (tx_take) begin
                tx_full <= 1'b0;
            end

            if (wr_acc && lane[LANE_IRQ_EN]) begin
                irq_en <= din[FLD_IRQ_EN_LSB +: 2];
            end
        end
    end

    assign irq = (irq_en[0] & rx_full) | (irq_en[1] & ~tx_full);

    // Write-data bits and lanes with no function
    logic unused_bits;
    assign unused_bits = ^{din[31:18], din[15:10], lane[3]};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave: a bit-banged SPI master,
//            CPU access tasks and scoreboard queues of expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = SYNC_STAGES + 2;
    localparam int HALF_MIN    = SYNC_STAGES + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  lane;
    logic        wr;
    logic        valid;
    logic        ready;
    logic        irq;
    logic        cs_n;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        miso_oe;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  m_tx [0:7];
    logic [7:0]  m_rx [0:7];
    logic [7:0]  exp_miso [$];
    logic [31:0] exp_dout [$];
    logic [7:0]  exp_rx   [$];

    spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .dout    (dout),
        .lane    (lane),
        .wr      (wr),
        .valid   (valid),
        .ready   (ready),
        .irq     (irq),
        .cs_n    (cs_n),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic u, input logic o,
                                       input logic t, input logic r,
                                       input logic [7:0] d);
        return {20'd0, u, o, t, r, d};
    endfunction

    // One CPU access; bounded wait for ready
    task automatic cpu_access(input logic w, input logic [31:0] d,
                              input logic [3:0] l, output logic [31:0] rd);
        int t;
        @(negedge clk);
        valid = 1'b1; wr = w; din = d; lane = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ready !== 1'b1 && t < 10);
        rd = dout;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cpu_ready: ready=%b required 1 within 10 cycles", ready);
        end
        valid = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] d, input logic [3:0] l);
        logic [31:0] unused_rd;
        cpu_access(1'b1, d, l, unused_rd);
    endtask

    task automatic cpu_read(output logic [31:0] rd);
        cpu_access(1'b0, 32'd0, 4'd0, rd);
    endtask

    // Pop the expected status word and compare with a fresh read
    task automatic check_status(input string name);
        logic [31:0] rd, ex;
        cpu_read(rd);
        ex = exp_dout.pop_front();
        vectors++;
        if (rd !== ex) begin
            miscompares++;
            $display("FAIL %s: dout=%h required %h", name, rd, ex);
        end
    endtask

    // Bit-banged mode-0 master; m_rx sampled just before each rising edge
    task automatic spi_xfer(input int nbits, input int half);
        @(negedge clk);
        cs_n = 1'b0;
        mosi = m_tx[0][7];
        repeat (half) @(negedge clk);
        vectors++;
        if (miso_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL miso_oe_frame: miso_oe=%b required 1", miso_oe);
        end
        for (int i = 0; i < nbits; i++) begin
            m_rx[i/8][7-(i%8)] = miso;
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
            if (i + 1 < nbits) mosi = m_tx[(i+1)/8][7-((i+1)%8)];
            repeat (half) @(negedge clk);
        end
        cs_n = 1'b1;
        mosi = 1'b1;
        repeat (half + 4) @(negedge clk);
    endtask

    // Compare master-received bytes against the scoreboard
    task automatic check_miso(input int nbytes, input string name);
        logic [7:0] ex;
        for (int b = 0; b < nbytes; b++) begin
            ex = exp_miso.pop_front();
            vectors++;
            if (m_rx[b] !== ex) begin
                miscompares++;
                $display("FAIL %s byte%0d: master got %h required %h", name, b, m_rx[b], ex);
            end
        end
    endtask

    task automatic test_reset;
        vectors++;
        if (dout !== 32'd0) begin miscompares++; $display("FAIL reset_dout: %h required 0", dout); end
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: %b required 0", ready); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: %b required 0", irq); end
        vectors++;
        if (miso !== 1'b1) begin miscompares++; $display("FAIL reset_miso: %b required 1", miso); end
        vectors++;
        if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_miso_oe: %b required 0", miso_oe); end
        exp_dout.push_back(st(0, 0, 0, 0, 8'h00));
        check_status("reset_status");
    endtask

    task automatic test_basic;
        cpu_write(32'h0000_00A5, 4'b0001);
        m_tx[0] = 8'h3C;
        exp_miso.push_back(8'hA5);
        spi_xfer(8, HALF);
        check_miso(1, "basic_miso");
        // empty tx at the end-of-byte reload flags an underrun
        exp_dout.push_back(st(1, 0, 0, 1, 8'h3C));
        check_status("basic_read1");
        exp_dout.push_back(st(1, 0, 0, 0, 8'h3C));
        check_status("basic_read2");
    endtask

    task automatic test_underrun;
        cpu_write(32'h0000_0200, 4'b0010);
        m_tx[0] = 8'h01;
        exp_miso.push_back(8'hFF);
        spi_xfer(8, HALF);
        check_miso(1, "underrun_miso");
        exp_dout.push_back(st(1, 0, 0, 1, 8'h01));
        check_status("underrun_set");
        cpu_write(32'h0000_0200, 4'b0010);
        exp_dout.push_back(st(0, 0, 0, 0, 8'h01));
        check_status("underrun_clear");
    endtask

    task automatic test_overrun;
        cpu_write(32'h0001_0000, 4'b0100);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL ovr_irq_idle: %b required 0", irq); end
        m_tx[0] = 8'h11;
        exp_miso.push_back(8'hFF);
        spi_xfer(8, HALF);
        check_miso(1, "ovr_miso1");
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL ovr_irq1: %b required 1", irq); end
        m_tx[0] = 8'h22;
        spi_xfer(8, HALF);
        exp_dout.push_back(st(1, 1, 0, 1, 8'h22));
        check_status("ovr_status");
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL ovr_irq_cleared: %b required 0", irq); end
        cpu_write(32'h0000_0300, 4'b0010);
    endtask

    task automatic test_partial;
        m_tx[0] = 8'hF0;
        spi_xfer(5, HALF);
        m_tx[0] = 8'h81;
        spi_xfer(8, HALF);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL partial_irq: %b required 1", irq); end
        exp_dout.push_back(st(1, 0, 0, 1, 8'h81));
        check_status("partial_status");
        cpu_write(32'h0000_0300, 4'b0010);
    endtask

    task automatic test_reset_mid;
        cpu_write(32'h0000_0077, 4'b0001);
        @(negedge clk);
        cs_n = 1'b0; mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b1; repeat (HALF) @(negedge clk);
        sck = 1'b0; repeat (HALF) @(negedge clk);
        sck = 1'b1; repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b1;
        vectors++;
        if (dout !== 32'd0) begin miscompares++; $display("FAIL rstmid_dout: %h required 0", dout); end
        vectors++;
        if (miso !== 1'b1 || miso_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_miso: miso=%b oe=%b required 1 0", miso, miso_oe);
        end
        vectors++;
        if (irq !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_irq_ready: irq=%b ready=%b required 0 0", irq, ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        cpu_write(32'h0000_00C3, 4'b0001);
        m_tx[0] = 8'h5A;
        exp_miso.push_back(8'hC3);
        spi_xfer(8, HALF);
        check_miso(1, "rstmid_miso_byte");
        exp_dout.push_back(st(1, 0, 0, 1, 8'h5A));
        check_status("rstmid_status");
        cpu_write(32'h0000_0300, 4'b0010);
    endtask

    task automatic test_back_to_back;
        logic [7:0]  txb [0:4];
        logic [31:0] rd;
        int writes, got, iter;
        txb[0] = 8'hA0; txb[1] = 8'hB1; txb[2] = 8'hC2; txb[3] = 8'hD3; txb[4] = 8'hE4;
        m_tx[0] = 8'h12; m_tx[1] = 8'h34; m_tx[2] = 8'h56; m_tx[3] = 8'h78;
        for (int b = 0; b < 4; b++) begin
            exp_miso.push_back(txb[b]);
            exp_rx.push_back(m_tx[b]);
        end
        cpu_write(32'h0003_0000, 4'b0100);
        cpu_write({24'd0, txb[0]}, 4'b0001);
        writes = 1; got = 0; iter = 0;
        fork
            spi_xfer(32, HALF_MIN);
            begin
                while ((got < 4 || writes < 5) && iter < 3000) begin
                    @(negedge clk);
                    iter++;
                    if (irq === 1'b1) begin
                        cpu_read(rd);
                        if (rd[8] === 1'b1) begin
                            vectors++;
                            if (rd[7:0] !== exp_rx[0]) begin
                                miscompares++;
                                $display("FAIL b2b_rx%0d: rx_data=%h required %h", got, rd[7:0], exp_rx[0]);
                            end
                            void'(exp_rx.pop_front());
                            got++;
                        end
                        if (rd[9] === 1'b0 && writes < 5) begin
                            cpu_write({24'd0, txb[writes]}, 4'b0001);
                            writes++;
                        end
                    end
                end
            end
        join
        vectors++;
        if (got != 4 || writes != 5) begin
            miscompares++;
            $display("FAIL b2b_service: got=%0d writes=%0d required 4 5", got, writes);
        end
        check_miso(4, "b2b_miso");
        exp_dout.push_back(st(0, 0, 0, 0, 8'h78));
        check_status("b2b_status");
        cpu_write(32'h0000_0000, 4'b0100);
    endtask

    // valid held through the ready cycle must yield one access only
    task automatic test_hold;
        int pulses;
        pulses = 0;
        @(negedge clk);
        valid = 1'b1; wr = 1'b0; din = 32'd0; lane = 4'd0;
        @(negedge clk);
        if (ready === 1'b1) pulses++;
        @(negedge clk);
        valid = 1'b0;
        if (ready === 1'b1) pulses++;
        repeat (3) begin
            @(negedge clk);
            if (ready === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL hold_ready_pulses: %0d required 1", pulses);
        end
    endtask

    initial begin
        rst = 1'b1; din = 32'd0; lane = 4'd0; wr = 1'b0; valid = 1'b0;
        cs_n = 1'b1; sck = 1'b0; mosi = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_underrun;
        test_overrun;
        test_partial;
        test_reset_mid;
        test_back_to_back;
        test_hold;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flop stages on each of sck, cs_n and mosi (minimum 2).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  32  CPU write data
- dout  out  32  CPU read data
- lane  in  4  byte-lane enables for writes
- wr  in  1  1 = write, 0 = read
- valid  in  1  CPU request strobe
- ready  out  1  one-cycle completion pulse
- irq  out  1  level interrupt
- cs_n  in  1  SPI chip select from master, active-low
- sck  in  1  SPI clock from master
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- miso_oe  out  1  miso output enable

Function
REQ-003 SHALL implement SPI mode 0, MSB first, 8-bit frames: sample mosi on sck rising, change miso on sck falling.
REQ-004 SHALL detect sck/cs_n edges from the last two synchronized samples only; no logic SHALL be clocked by sck.
REQ-005 SHALL operate correctly for sck high and low phases of at least SYNC_STAGES+1 clk cycles each; behaviour at faster sck is undefined.
REQ-006 SHALL keep state IDLE while synchronized cs_n = 1; miso_oe = 0 and miso = 1 in IDLE.
REQ-007 On synchronized cs_n falling edge: state -> SHIFT; bit counter = 0; shifter = tx_data if tx_full, else 8'hFF with tx_underrun set; tx_full cleared; miso_oe = 1 on the same cycle.
REQ-008 In SHIFT: miso = shifter[7]; each sck rising edge captures mosi into rx_shift LSB and increments the bit counter (3 bits, wraps 7 -> 0).
REQ-009 On the 8th rising edge: rx_data <= completed byte, rx_full <= 1; if rx_full was already 1, rx_overrun <= 1 and rx_data is still overwritten.
REQ-010 Each sck falling edge in SHIFT shifts the shifter left by one; the falling edge after the 8th rising edge instead reloads the shifter per REQ-007 (tx_data or 8'hFF with underrun).
REQ-011 miso SHALL change no later than SYNC_STAGES+1 clk cycles after the external sck falling edge.
REQ-012 On cs_n rising edge in SHIFT: state -> IDLE; partial byte discarded; rx_data, rx_full unchanged.
REQ-013 Read (valid & ~wr): ready = 1 on the following cycle with dout = {20'd0, tx_underrun, rx_overrun, tx_full, rx_full, rx_data[7:0]}; the read clears rx_full.
REQ-014 Write (valid & wr): ready = 1 on the following cycle; lane[0] loads tx_data = din[7:0] and sets tx_full; lane[1] with din[8] = 1 clears rx_overrun, with din[9] = 1 clears tx_underrun; lane[2] loads irq_en = din[17:16].
REQ-015 When a CPU write of tx_data and a shifter reload fall on the same cycle, the reload SHALL use the old tx_data/tx_full state and the write SHALL set tx_full afterwards.
REQ-016 When a CPU read and a byte completion fall on the same cycle, the read SHALL return the old rx_data and rx_full SHALL end at 1.
REQ-017 irq = (irq_en[0] & rx_full) | (irq_en[1] & ~tx_full).
REQ-018 A new request SHALL NOT be accepted while ready is high; valid held across ready yields exactly one access.

Reset
REQ-019 rst SHALL force state IDLE, all synchronizer stages to 1 (sck to 0), shifter = 8'hFF, counter = 0, rx_data = 0, tx_data = 0, all flags 0, irq_en = 0, dout = 0, ready = 0, irq = 0, miso = 1, miso_oe = 0.
REQ-020 rst asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-021 Status bit positions, register field offsets and FSM state encodings SHALL reside in a shared package spi_pkg.
REQ-022 One sub-module, spi_sync (parameterized multi-stage synchronizer with reset value), SHALL be instantiated three times.

Verification
REQ-023 Write tx_data 8'hA5; master sends 8'h3C -> master receives 8'hA5; read returns rx_data 8'h3C, rx_full = 1; second read shows rx_full = 0.
REQ-024 No tx write; master sends 8'h01 -> master receives 8'hFF; status tx_underrun = 1; write lane[1] din[9] = 1 -> tx_underrun = 0.
REQ-025 Master sends 8'h11 then 8'h22 with no CPU read -> rx_data = 8'h22, rx_overrun = 1, irq = 1 with irq_en = 2'b01.
REQ-026 cs_n raised after 5 bits of 8'hF0, then full frame 8'h81 -> rx_data = 8'h81, exactly one byte completion.
REQ-027 rst pulsed after 3 sck edges -> all outputs at reset values; next full frame 8'h5A is received correctly.
REQ-028 sck half-period = SYNC_STAGES+1 clk cycles, 4 back-to-back frames with tx reloaded via irq -> all bytes in both directions correct, no underrun.
